// File: rtl/mem_arbiter.sv
// Shares the single-port image memory between a burst reader and a single-word writer, round-robin per transaction.
// Command issues 1 cycle after the grant edge; read data returns RD_LAT+1 cycles after issue, with no backpressure on returns.
module mem_arbiter #(
    parameter int DATA_WIDTH = 24,
    parameter int BUS_WIDTH  = 32,
    parameter int RD_LAT     = 1,
    parameter int MAX_BURST  = 9
) (
    input  logic                  mem_arbiter_CLK,
    input  logic                  mem_arbiter_RST,
    input  logic                  mem_arbiter_RREQ,
    input  logic [BUS_WIDTH-1:0]  mem_arbiter_RADDR,
    input  logic                  mem_arbiter_RLAST,
    output logic                  mem_arbiter_RGNT,
    output logic [DATA_WIDTH-1:0] mem_arbiter_RDATA,
    output logic                  mem_arbiter_RVALID,
    input  logic                  mem_arbiter_WREQ,
    input  logic [BUS_WIDTH-1:0]  mem_arbiter_WADDR,
    input  logic [DATA_WIDTH-1:0] mem_arbiter_WDATA,
    output logic                  mem_arbiter_WGNT,
    output logic [BUS_WIDTH-1:0]  mem_arbiter_MEMADDR,
    output logic [1:0]            mem_arbiter_MEMW,
    output logic [DATA_WIDTH-1:0] mem_arbiter_MEMWDATA,
    input  logic [DATA_WIDTH-1:0] mem_arbiter_MEMRDATA,
    output logic                  mem_arbiter_BUSY
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int DW = $clog2(RD_LAT + 1);

    localparam logic [1:0] CMD_IDLE = 2'd0;
    localparam logic [1:0] CMD_WR   = 2'd1;
    localparam logic [1:0] CMD_RD   = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_RBURST, S_WRITE, S_DRAIN} state_t;

    state_t                r_state;
    logic                  r_ptr_wr;
    logic [CW-1:0]         r_count;
    logic [DW-1:0]         r_drain;
    logic [RD_LAT-1:0]     r_vpipe;
    logic [BUS_WIDTH-1:0]  r_memaddr;
    logic [1:0]            r_memw;
    logic [DATA_WIDTH-1:0] r_memwdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    logic                  w_rgnt;
    logic                  w_wgnt;
    logic [CW-1:0]         w_count_nxt;
    logic                  w_last_word;

    // Grants are suppressed while reset is held so no transfer is lost to a reset edge.
    always_comb begin
        w_rgnt = 1'b0;
        w_wgnt = 1'b0;
        if (!mem_arbiter_RST) begin
            case (r_state)
                S_IDLE: begin
                    w_rgnt = mem_arbiter_RREQ && (!mem_arbiter_WREQ || !r_ptr_wr);
                    w_wgnt = mem_arbiter_WREQ && (!mem_arbiter_RREQ || r_ptr_wr);
                end
                S_RBURST: w_rgnt = mem_arbiter_RREQ;
                default: ;
            endcase
        end
    end

    assign w_count_nxt = (r_state == S_IDLE) ? CW'(1) : r_count + CW'(1);
    assign w_last_word = mem_arbiter_RLAST || (w_count_nxt == CW'(MAX_BURST));

    always_ff @(posedge mem_arbiter_CLK or posedge mem_arbiter_RST) begin
        if (mem_arbiter_RST) begin
            r_state    <= S_IDLE;
            r_ptr_wr   <= 1'b0;
            r_count    <= '0;
            r_drain    <= '0;
            r_vpipe    <= '0;
            r_memaddr  <= '0;
            r_memw     <= CMD_IDLE;
            r_memwdata <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
        end else begin
            r_memw <= CMD_IDLE;

            // Valid tracker: its tap lines up with the cycle MEMRDATA holds the oldest issued read.
            r_vpipe[0] <= (r_memw == CMD_RD);
            for (int i = 1; i < RD_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
            r_rvalid <= r_vpipe[RD_LAT-1];
            if (r_vpipe[RD_LAT-1]) begin
                r_rdata <= mem_arbiter_MEMRDATA;
            end

            case (r_state)
                S_IDLE, S_RBURST: begin
                    if (w_rgnt) begin
                        r_memw    <= CMD_RD;
                        r_memaddr <= mem_arbiter_RADDR;
                        r_count   <= w_count_nxt;
                        r_state   <= w_last_word ? S_DRAIN : S_RBURST;
                        r_drain   <= '0;
                    end else if (w_wgnt) begin
                        r_memw     <= CMD_WR;
                        r_memaddr  <= mem_arbiter_WADDR;
                        r_memwdata <= mem_arbiter_WDATA;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_ptr_wr <= 1'b0;
                    r_state  <= S_IDLE;
                end
                S_DRAIN: begin
                    if (r_drain == DW'(RD_LAT)) begin
                        r_ptr_wr <= 1'b1;
                        r_count  <= '0;
                        r_drain  <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_arbiter_RGNT     = w_rgnt;
    assign mem_arbiter_WGNT     = w_wgnt;
    assign mem_arbiter_RDATA    = r_rdata;
    assign mem_arbiter_RVALID   = r_rvalid;
    assign mem_arbiter_MEMADDR  = r_memaddr;
    assign mem_arbiter_MEMW     = r_memw;
    assign mem_arbiter_MEMWDATA = r_memwdata;
    assign mem_arbiter_BUSY     = (r_state != S_IDLE) || (r_memw != CMD_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences for gaps/max-burst/async reset, then random traffic vs a transaction model.
module tb_mem_arbiter;
    localparam int RD_LAT    = 1;
    localparam int MAX_BURST = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rreq = 1'b0, rlast = 1'b0, wreq = 1'b0;
    logic [31:0] raddr = '0, waddr = '0;
    logic [23:0] wdata = '0;
    logic [23:0] memrdata = '0;
    logic        rgnt, wgnt, rvalid, busy;
    logic [23:0] rdata, memwdata;
    logic [31:0] memaddr;
    logic [1:0]  memw;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .mem_arbiter_CLK      (clk),
        .mem_arbiter_RST      (rst),
        .mem_arbiter_RREQ     (rreq),
        .mem_arbiter_RADDR    (raddr),
        .mem_arbiter_RLAST    (rlast),
        .mem_arbiter_RGNT     (rgnt),
        .mem_arbiter_RDATA    (rdata),
        .mem_arbiter_RVALID   (rvalid),
        .mem_arbiter_WREQ     (wreq),
        .mem_arbiter_WADDR    (waddr),
        .mem_arbiter_WDATA    (wdata),
        .mem_arbiter_WGNT     (wgnt),
        .mem_arbiter_MEMADDR  (memaddr),
        .mem_arbiter_MEMW     (memw),
        .mem_arbiter_MEMWDATA (memwdata),
        .mem_arbiter_MEMRDATA (memrdata),
        .mem_arbiter_BUSY     (busy)
    );

    // Memory model with one cycle read latency, indexed by the low address byte.
    logic [23:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);
    always @(posedge clk) begin
        if (memw == 2'd2) memrdata <= mem[memaddr[7:0]];
        if (memw == 2'd1) mem[memaddr[7:0]] = memwdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rq, input logic [31:0] ra, input logic rl, input logic wq,
                         input logic [31:0] wa, input logic [23:0] wd);
        @(posedge clk); #1;
        rreq = rq; raddr = ra; rlast = rl; wreq = wq; waddr = wa; wdata = wd;
        @(negedge clk);
    endtask

    // Transaction-level reference: bursts, post-transaction blackout, alternation after each transaction.
    typedef struct { logic [23:0] d; int due; } rd_t;
    rd_t         rd_q[$];
    int          cyc = 0, words = 0, cool = 0, wwait = 0;
    logic        in_b = 1'b0, last_rd = 1'b0, blocked, er, ew;
    logic        p_r = 1'b0, p_w = 1'b0;
    logic [31:0] p_ra = '0, p_wa = '0;
    logic [23:0] p_wd = '0;
    logic [1:0]  exp_cmd;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            rd_q.delete();
            p_r = 1'b0; p_w = 1'b0; in_b = 1'b0; words = 0; cool = 0; last_rd = 1'b0; wwait = 0;
        end else begin
            exp_cmd = p_r ? 2'd2 : (p_w ? 2'd1 : 2'd0);
            blocked = (cool > 0);
            chk("mon_memw", 32'(memw), 32'(exp_cmd));
            if (p_r) chk("mon_rd_addr", memaddr, p_ra);
            if (p_w) begin
                chk("mon_wr_addr", memaddr, p_wa);
                chk("mon_wr_data", 32'(memwdata), 32'(p_wd));
            end
            chk("mon_busy", 32'(busy), 32'(in_b || blocked || (exp_cmd != 2'd0)));
            if (blocked) begin
                er = 1'b0; ew = 1'b0;
            end else if (in_b) begin
                er = rreq; ew = 1'b0;
            end else begin
                er = rreq && (!wreq || !last_rd);
                ew = wreq && (!rreq || last_rd);
            end
            chk("mon_rgnt", 32'(rgnt), 32'(er));
            chk("mon_wgnt", 32'(wgnt), 32'(ew));
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                chk("mon_rvalid", 32'(rvalid), 32'd1);
                chk("mon_rdata", 32'(rdata), 32'(rd_q[0].d));
                void'(rd_q.pop_front());
            end else begin
                chk("mon_rvalid_idle", 32'(rvalid), 32'd0);
            end
            if (memw == 2'd2) rd_q.push_back('{d: mem[memaddr[7:0]], due: cyc + RD_LAT + 1});
            if (wreq && !wgnt) wwait++; else wwait = 0;
            if (wreq) chk("mon_w_starve", 32'(wwait < 80), 32'd1);
            if (blocked) cool--;
            if (rgnt) begin
                if (!in_b) begin in_b = 1'b1; words = 0; end
                words++;
                if (rlast || words == MAX_BURST) begin
                    in_b = 1'b0; cool = RD_LAT + 1; last_rd = 1'b1;
                end
            end else if (wgnt) begin
                cool = 1; last_rd = 1'b0;
            end
            p_r = rgnt; p_w = wgnt; p_ra = raddr; p_wa = waddr; p_wd = wdata;
        end
    end

    typedef struct {
        logic rq; logic [3:0] ra; logic rl; logic wq;
        logic e_r; logic e_w; logic [1:0] e_memw; logic e_busy;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic rq, input int ra, input logic rl, input logic wq,
                       input logic e_r, input logic e_w, input int e_memw, input logic e_busy);
        tbl.push_back('{rq: rq, ra: 4'(ra), rl: rl, wq: wq, e_r: e_r, e_w: e_w,
                        e_memw: 2'(e_memw), e_busy: e_busy});
    endtask

    logic        rg, wg, rq_i, rl_i, r_on, w_pend;
    logic [31:0] ra_i, wa_i, r_addr;
    logic [23:0] wd_i;
    int          r_left;

    initial begin
        // Reader-only 9-word burst, drain, lone write, simultaneous request, single-word burst.
        for (int i = 0; i < 9; i++) add(1, i, i == 8, 0, 1, 0, (i == 0) ? 0 : 2, i != 0);
        add(0, 0, 0, 0, 0, 0, 2, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(1, i, i == 8, 1, 1, 0, (i == 0) ? 0 : 2, i != 0);
        add(1, 0, 0, 1, 0, 0, 2, 1);
        add(1, 0, 0, 1, 0, 0, 0, 1);
        add(1, 0, 0, 1, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 0, 1, 1);
        add(1, 0, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst_memw", 32'(memw), 32'd0);
        chk("rst_memaddr", memaddr, 32'd0);
        chk("rst_memwdata", 32'(memwdata), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #2; rst = 1'b0;

        foreach (tbl[k]) begin
            drive(tbl[k].rq, 32'(tbl[k].ra), tbl[k].rl, tbl[k].wq, 32'h40400, 24'hABCDEF);
            chk($sformatf("vec%0d_rgnt", k), 32'(rgnt), 32'(tbl[k].e_r));
            chk($sformatf("vec%0d_wgnt", k), 32'(wgnt), 32'(tbl[k].e_w));
            chk($sformatf("vec%0d_memw", k), 32'(memw), 32'(tbl[k].e_memw));
            chk($sformatf("vec%0d_busy", k), 32'(busy), 32'(tbl[k].e_busy));
            if (tbl[k].e_memw == 2'd1) begin
                chk("vec_wr_addr", memaddr, 32'h40400);
                chk("vec_wr_data", 32'(memwdata), 32'hABCDEF);
            end
        end

        // Mid-burst write request plus 3-cycle reader gap; RLAST never set so MAX_BURST closes it.
        for (int w = 0; w < 4; w++) begin
            drive(1, 32'(w), 0, w >= 2, 32'h500, 24'h111);
            chk("gap_rgnt", 32'(rgnt), 32'd1);
            chk("gap_wgnt", 32'(wgnt), 32'd0);
        end
        for (int g = 0; g < 3; g++) begin
            drive(0, 32'd4, 0, 1, 32'h500, 24'h111);
            chk("gap_idle_rgnt", 32'(rgnt), 32'd0);
            chk("gap_idle_wgnt", 32'(wgnt), 32'd0);
            chk("gap_memw", 32'(memw), (g == 0) ? 32'd2 : 32'd0);
        end
        for (int w = 4; w < 9; w++) begin
            drive(1, 32'(w), 0, 1, 32'h500, 24'h111);
            chk("resume_rgnt", 32'(rgnt), 32'd1);
            chk("resume_memw", 32'(memw), (w == 4) ? 32'd0 : 32'd2);
        end
        for (int d = 0; d < 2; d++) begin
            drive(1, 32'd9, 0, 1, 32'h500, 24'h111);
            chk("max_drain_rgnt", 32'(rgnt), 32'd0);
            chk("max_drain_wgnt", 32'(wgnt), 32'd0);
        end
        drive(1, 32'd9, 0, 1, 32'h500, 24'h111);
        chk("max_writer_pref", 32'(wgnt), 32'd1);
        chk("max_writer_pref_r", 32'(rgnt), 32'd0);
        drive(1, 32'd9, 1, 0, 32'h500, 24'h111);
        chk("max_write_cycle", 32'(memw), 32'd1);
        chk("max_write_rgnt", 32'(rgnt), 32'd0);
        drive(1, 32'd9, 1, 0, 32'h500, 24'h111);
        chk("tenth_rgnt", 32'(rgnt), 32'd1);
        drive(0, 32'd0, 0, 0, 32'h500, 24'h111);
        chk("tenth_memaddr", memaddr, 32'd9);
        repeat (2) drive(0, 32'd0, 0, 0, 32'h500, 24'h111);

        // Async reset between edges while the 5th burst word is presented.
        for (int w = 0; w < 4; w++) begin
            drive(1, 32'(w), 0, 0, 32'h123, 24'h456);
            chk("prerst_rgnt", 32'(rgnt), 32'd1);
        end
        @(posedge clk); #1;
        rreq = 1'b1; raddr = 32'd4; rlast = 1'b0;
        #2; rst = 1'b1;
        #1;
        chk("arst_memw", 32'(memw), 32'd0);
        chk("arst_memaddr", memaddr, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rvalid", 32'(rvalid), 32'd0);
        chk("arst_rdata", 32'(rdata), 32'd0);
        wreq = 1'b1; waddr = 32'h123; wdata = 24'h456;
        @(posedge clk); #2; rst = 1'b0;
        @(negedge clk);
        chk("postrst_rgnt", 32'(rgnt), 32'd1);
        chk("postrst_wgnt", 32'(wgnt), 32'd0);
        for (int w = 5; w < 13; w++) drive(1, 32'(w), w == 12, 1, 32'h123, 24'h456);
        repeat (2) drive(0, 32'd0, 0, 1, 32'h123, 24'h456);
        drive(0, 32'd0, 0, 1, 32'h123, 24'h456);
        chk("postrst_wgnt_after_drain", 32'(wgnt), 32'd1);
        repeat (2) drive(0, 32'd0, 0, 0, 32'h123, 24'h456);

        // Random protocol-compliant traffic, checked by the transaction model.
        rg = 1'b0; wg = 1'b0; rq_i = 1'b0; rl_i = 1'b0; r_on = 1'b0; w_pend = 1'b0;
        ra_i = '0; wa_i = '0; wd_i = '0; r_addr = '0; r_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rg) begin
                r_addr++;
                r_left--;
                if (r_left == 0) r_on = 1'b0;
            end
            if (wg) w_pend = 1'b0;
            if (!r_on && $urandom_range(0, 3) == 0) begin
                r_on = 1'b1; r_left = int'($urandom_range(1, 12)); r_addr = $urandom;
            end
            if (!w_pend && $urandom_range(0, 4) == 0) begin
                w_pend = 1'b1; wa_i = $urandom; wd_i = 24'($urandom);
            end
            if (!(rq_i && !rg)) begin
                rq_i = r_on && ($urandom_range(0, 4) != 0);
                ra_i = r_addr;
                rl_i = (r_left == 1);
            end
            drive(rq_i, ra_i, rl_i, w_pend, wa_i, wd_i);
            rg = rgnt; wg = wgnt;
        end
        repeat (6) drive(0, 32'd0, 0, 0, 32'd0, 24'd0);
        chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port image memory between two requesters: the window fetcher (read bursts) and the result writer (single-word writes).
- Arbitrates round-robin at transaction granularity, so a full window fetch is never split by a write.
- Drives the memory address, command and write-data lines, and returns read data to the fetcher in issue order.
- Sits between the filter-side requesters and the image/result memory.

Parameters:
- DATA_WIDTH, 24, pixel width (read and write data).
- BUS_WIDTH, 32, memory address width.
- RD_LAT, 1, cycles from the read-issue cycle to MEMRDATA being valid (must be 1 or more).
- MAX_BURST, 9, maximum read words per burst (one 3x3 window).

Ports:
- mem_arbiter_CLK  in  1  clock; all logic on the rising edge.
- mem_arbiter_RST  in  1  asynchronous, active-high reset.
- mem_arbiter_RREQ  in  1  fetcher read request; address valid.
- mem_arbiter_RADDR  in  BUS_WIDTH  fetcher read address.
- mem_arbiter_RLAST  in  1  marks the final word of the fetcher burst.
- mem_arbiter_RGNT  out  1  combinational; RADDR is captured at this edge.
- mem_arbiter_RDATA  out  DATA_WIDTH  returned read data.
- mem_arbiter_RVALID  out  1  RDATA valid, one pulse per word.
- mem_arbiter_WREQ  in  1  writer request.
- mem_arbiter_WADDR  in  BUS_WIDTH  write address.
- mem_arbiter_WDATA  in  DATA_WIDTH  write data.
- mem_arbiter_WGNT  out  1  combinational; WADDR/WDATA are captured at this edge.
- mem_arbiter_MEMADDR  out  BUS_WIDTH  memory address.
- mem_arbiter_MEMW  out  2  memory command: 0 idle, 1 write, 2 read.
- mem_arbiter_MEMWDATA  out  DATA_WIDTH  memory write data.
- mem_arbiter_MEMRDATA  in  DATA_WIDTH  memory read data.
- mem_arbiter_BUSY  out  1  high when state is not IDLE or MEMW is not 0.

Behaviour:
- Reset (async, any time, including mid-burst):
  - State goes to IDLE.
  - MEMADDR=0, MEMW=0, MEMWDATA=0, RDATA=0, RVALID=0, BUSY=0.
  - Burst counter cleared; in-flight read pipeline flushed (its data is never returned).
  - Round-robin pointer set to "reader first".
- Handshake: a requester holds REQ and address/data stable until it sees GNT high; the transfer occurs at that clock edge. GNT is only ever high when the matching REQ is high.
- MEMADDR, MEMW and MEMWDATA are registered. The command appears in the cycle after the GNT edge and lasts exactly one cycle; MEMW returns to 0 unless a new transfer was granted.
- State machine:
  - IDLE, only RREQ: RGNT=1, go to RBURST, count=1.
  - IDLE, only WREQ: WGNT=1, go to WRITE.
  - IDLE, both requesting: pointer decides.
  - IDLE, neither requesting: stay.
  - RBURST: RGNT=RREQ. Each granted word issues MEMW=2 and increments count.
    - If RREQ drops, the cycle issues MEMW=0 and the burst stays open; WREQ is not served.
    - Burst closes at the edge granting a word with RLAST=1, or when count reaches MAX_BURST (RLAST ignored after that). Then go to DRAIN.
  - WRITE: one cycle with MEMW=1, MEMADDR=WADDR, MEMWDATA=WDATA. Pointer set to reader first. Go to IDLE. No grants in this state.
  - DRAIN: hold RD_LAT+1 cycles so all outstanding RVALIDs return. Pointer set to writer first. Go to IDLE. No grants in this state.
- Fairness: between two writes at most one read burst; between two bursts at most one write. Neither requester starves.
- Read return:
  - A RD_LAT-deep valid shift register tracks issues.
  - MEMRDATA is registered into RDATA, so RVALID=1 in cycle issue+RD_LAT+1.
  - Returns are in issue order, one word per cycle max, with no backpressure.
- Throughput:
  - Back-to-back reads inside a burst: 1 word/cycle.
  - Writes: at most 1 per 2 cycles (WRITE then IDLE).
  - Idle-to-first-command latency: 1 cycle after the GNT edge.
- Address/data pass through unmodified. No range check is done; the requesters own address generation.

Test Plan:
1. RD_LAT=1. RREQ alone, 9 addresses 0..8 with RLAST on the 9th:
   - RGNT for 9 consecutive cycles; MEMW=2 for 9 consecutive cycles, MEMADDR 0..8.
   - RVALID high for 9 cycles starting 2 cycles after the first issue; RDATA equals the memory model contents.
   - Then DRAIN for 2 cycles, then IDLE with BUSY=0.
2. WREQ alone, WADDR=0x40400, WDATA=0xABCDEF:
   - WGNT in the same cycle as the request.
   - Next cycle MEMW=1, MEMADDR=0x40400, MEMWDATA=0xABCDEF; the following cycle MEMW=0.
3. RREQ and WREQ raised in the same cycle after reset:
   - Reader served first (full burst).
   - WGNT is the first grant after DRAIN, before the next burst starts even though RREQ is still high.
4. WREQ raised mid-burst, and RREQ dropped for 3 cycles mid-burst:
   - No WGNT until the burst closes.
   - MEMW=0 for the 3 gap cycles; count unchanged; burst resumes.
5. RLAST held low for 12 words:
   - Burst closes after exactly 9 issues (MAX_BURST).
   - 10th RGNT comes only after DRAIN, and the writer is preferred if WREQ is high.
6. RST asserted asynchronously between clock edges on the 5th burst word:
   - Outputs go to 0 immediately.
   - No RVALID afterwards for flushed reads.
   - After release, the first grant goes to the reader when both request.
